// File: rtl/hazard_mac_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / MAC sequencing controller.
package hazard_mac_ctrl_pkg;

    typedef logic [1:0] mac_op_t;

    localparam mac_op_t    MAC_NOP      = mac_op_t'(2'd0);
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    // Occupancy counter is sized for the largest legal MAC latency.
    localparam int MAC_LAT_MAX = 16;
    localparam int CNT_W       = $clog2(MAC_LAT_MAX);

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_t;

    function automatic logic is_issue(input logic write_e, input mac_op_t op_e);
        return write_e && (op_e != MAC_NOP);
    endfunction

endpackage

// File: rtl/hazard_mac_ctrl_occ.sv
// MAC occupancy tracker: issue FSM plus down-counter, producing the start pulse,
// the busy flag and a sticky flag for issues attempted while the MAC is occupied.
module mac_occ_counter
    import hazard_mac_ctrl_pkg::*;
#(
    parameter int MAC_LAT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      issue,
    output logic      mac_start,
    output logic      mac_busy,
    output logic      mac_err,
    output hz_state_t state_dbg
);

    // BUSY covers the MAC_LAT-1 cycles after the issue cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = (MAC_LAT > 1) ? CNT_W'(MAC_LAT - 2) : '0;
    localparam bit               MULTI    = (MAC_LAT > 1);

    hz_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_q, err_n;
    logic             start_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err_q;
        start_c = 1'b0;
        case (state)
            HZ_IDLE: begin
                if (issue) begin
                    start_c = 1'b1;
                    if (MULTI) begin
                        state_n = HZ_BUSY;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            HZ_BUSY: begin
                // An issue here is rejected: no start, no reload, just flagged.
                if (issue) begin
                    err_n = 1'b1;
                end
                if (cnt == '0) begin
                    state_n = HZ_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = HZ_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign mac_start = start_c && !rst;
    assign mac_busy  = (state == HZ_BUSY) && !rst;
    assign mac_err   = err_q;
    assign state_dbg = state;

endmodule

// File: rtl/hazard_mac_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: MAC-occupancy and load-use
// stalls, branch flushes, MAC issue pulse and a saturating stall-cycle counter.
module hazard_mac_ctrl
    import hazard_mac_ctrl_pkg::*;
#(
    parameter int MAC_LAT = 4,
    parameter int REG_AW  = 5,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mac_write_e,
    input  mac_op_t           mac_op_e,
    input  logic              mac_use_d,
    input  logic [1:0]        result_src_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              pc_src_e,
    output logic              mac_start,
    output logic              mac_busy,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mac_err,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam bit MULTI = (MAC_LAT > 1);

    logic      issue;
    logic      mac_hz;
    logic      lu_hz;
    hz_state_t occ_state;

    assign issue = is_issue(mac_write_e, mac_op_e);

    mac_occ_counter #(
        .MAC_LAT (MAC_LAT)
    ) u_occ (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .mac_start (mac_start),
        .mac_busy  (mac_busy),
        .mac_err   (mac_err),
        .state_dbg (occ_state)
    );

    // A D-stage MAC consumer must also wait in the issue cycle of a multi-cycle op.
    assign mac_hz = mac_use_d && ((occ_state == HZ_BUSY) || (issue && MULTI));
    assign lu_hz  = (result_src_e == RES_SRC_LOAD) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Purely combinational so the enables reach the pipeline registers in-cycle.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (mac_hz || lu_hz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_d && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_mac_ctrl.sv
// Directed bench for hazard_mac_ctrl: default build, a MAC_LAT=1 build and a
// PERF_W=4 build share one stimulus bus.
module tb_hazard_mac_ctrl;
    import hazard_mac_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       mac_write_e;
    mac_op_t    mac_op_e;
    logic       mac_use_d;
    logic [1:0] result_src_e;
    logic [4:0] rd_e, rs1_d, rs2_d;
    logic       pc_src_e;

    logic        d0_start, d0_busy, d0_sf, d0_sd, d0_fd, d0_fe, d0_err;
    logic [15:0] d0_cnt;
    logic        d1_start, d1_busy, d1_sf, d1_sd, d1_fd, d1_fe, d1_err;
    logic [15:0] d1_cnt;
    logic        dp_start, dp_busy, dp_sf, dp_sd, dp_fd, dp_fe, dp_err;
    logic [3:0]  dp_cnt;

    int checks = 0;
    int errors = 0;

    hazard_mac_ctrl #(.MAC_LAT(4), .REG_AW(5), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .mac_write_e(mac_write_e), .mac_op_e(mac_op_e),
        .mac_use_d(mac_use_d), .result_src_e(result_src_e), .rd_e(rd_e),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .pc_src_e(pc_src_e),
        .mac_start(d0_start), .mac_busy(d0_busy), .stall_f(d0_sf), .stall_d(d0_sd),
        .flush_d(d0_fd), .flush_e(d0_fe), .mac_err(d0_err), .stall_cnt(d0_cnt)
    );

    hazard_mac_ctrl #(.MAC_LAT(1), .REG_AW(5), .PERF_W(16)) dut_lat1 (
        .clk(clk), .rst(rst), .mac_write_e(mac_write_e), .mac_op_e(mac_op_e),
        .mac_use_d(mac_use_d), .result_src_e(result_src_e), .rd_e(rd_e),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .pc_src_e(pc_src_e),
        .mac_start(d1_start), .mac_busy(d1_busy), .stall_f(d1_sf), .stall_d(d1_sd),
        .flush_d(d1_fd), .flush_e(d1_fe), .mac_err(d1_err), .stall_cnt(d1_cnt)
    );

    hazard_mac_ctrl #(.MAC_LAT(4), .REG_AW(5), .PERF_W(4)) dut_perf4 (
        .clk(clk), .rst(rst), .mac_write_e(mac_write_e), .mac_op_e(mac_op_e),
        .mac_use_d(mac_use_d), .result_src_e(result_src_e), .rd_e(rd_e),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .pc_src_e(pc_src_e),
        .mac_start(dp_start), .mac_busy(dp_busy), .stall_f(dp_sf), .stall_d(dp_sd),
        .flush_d(dp_fd), .flush_e(dp_fe), .mac_err(dp_err), .stall_cnt(dp_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [1:0]  op;
        logic        use_d;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        pc;
        logic        e_start;
        logic        e_busy;
        logic        e_stall;
        logic        e_fd;
        logic        e_fe;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic w, input logic [1:0] op, input logic use_d,
                                input logic [1:0] src, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic pc, input logic st, input logic bz,
                                input logic sl, input logic fd, input logic fe,
                                input logic er, input logic [15:0] cnt);
        vec_t v;
        v.w = w; v.op = op; v.use_d = use_d; v.src = src; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.e_start = st; v.e_busy = bz;
        v.e_stall = sl; v.e_fd = fd; v.e_fe = fe; v.e_err = er; v.e_cnt = cnt;
        return v;
    endfunction

    // Scoreboard compare
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver
    task automatic drive(input logic w, input logic [1:0] op, input logic use_d,
                         input logic [1:0] src, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic pc);
        mac_write_e  = w;
        mac_op_e     = op;
        mac_use_d    = use_d;
        result_src_e = src;
        rd_e         = rd;
        rs1_d        = rs1;
        rs2_d        = rs2;
        pc_src_e     = pc;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " start"}, 16'(d0_start), 16'd0);
        check({tag, " busy"},  16'(d0_busy),  16'd0);
        check({tag, " hz"},    16'({d0_sf, d0_sd, d0_fd, d0_fe}), 16'd0);
        check({tag, " err"},   16'(d0_err),   16'd0);
        check({tag, " cnt"},   d0_cnt,        16'd0);
    endtask

    initial begin
        // Reset asserted with every hazard source active: outputs must stay low.
        rst = 1'b1;
        drive(1'b1, 2'd1, 1'b1, 2'b01, 5'd5, 5'd5, 5'd5, 1'b1);
        #3;
        check_zero_outputs("reset");
        check("reset lat1 start", 16'(d1_start), 16'd0);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b0;

        //        w  op  use src    rd  rs1 rs2 pc | st bz sl fd fe er cnt
        tbl[0]  = mk(1, 1, 1, 2'b00, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 1);
        tbl[2]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 2);
        tbl[3]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 3);
        tbl[4]  = mk(0, 3, 1, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        tbl[5]  = mk(0, 0, 0, 2'b01, 5, 1, 5, 0,  0, 0, 1, 0, 1, 0, 4);
        tbl[6]  = mk(0, 0, 0, 2'b01, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5);
        tbl[7]  = mk(0, 0, 0, 2'b00, 5, 5, 0, 0,  0, 0, 0, 0, 0, 0, 5);
        tbl[8]  = mk(0, 0, 0, 2'b01, 7, 7, 2, 0,  0, 0, 1, 0, 1, 0, 5);
        tbl[9]  = mk(1, 0, 1, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 6);
        tbl[10] = mk(1, 2, 1, 2'b00, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 6);
        tbl[11] = mk(0, 0, 1, 2'b00, 0, 0, 0, 1,  0, 1, 0, 1, 1, 0, 7);
        tbl[12] = mk(0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 7);
        tbl[13] = mk(0, 0, 1, 2'b01, 4, 4, 0, 1,  0, 1, 0, 1, 1, 0, 8);
        tbl[14] = mk(0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8);
        tbl[15] = mk(0, 0, 0, 2'b01, 3, 3, 0, 1,  0, 0, 0, 1, 1, 0, 8);
        tbl[16] = mk(1, 2, 0, 2'b00, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8);
        tbl[17] = mk(1, 3, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 8);
        tbl[18] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 8);
        tbl[19] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 8);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].w, tbl[i].op, tbl[i].use_d, tbl[i].src, tbl[i].rd,
                  tbl[i].rs1, tbl[i].rs2, tbl[i].pc);
            @(negedge clk);
            check($sformatf("r%0d mac_start", i), 16'(d0_start), 16'(tbl[i].e_start));
            check($sformatf("r%0d mac_busy", i),  16'(d0_busy),  16'(tbl[i].e_busy));
            check($sformatf("r%0d stall_f", i),   16'(d0_sf),    16'(tbl[i].e_stall));
            check($sformatf("r%0d stall_d", i),   16'(d0_sd),    16'(tbl[i].e_stall));
            check($sformatf("r%0d flush_d", i),   16'(d0_fd),    16'(tbl[i].e_fd));
            check($sformatf("r%0d flush_e", i),   16'(d0_fe),    16'(tbl[i].e_fe));
            check($sformatf("r%0d mac_err", i),   16'(d0_err),   16'(tbl[i].e_err));
            check($sformatf("r%0d stall_cnt", i), d0_cnt,        tbl[i].e_cnt);
        end

        // Asynchronous reset in the middle of BUSY, no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async rst");
        @(negedge clk);
        rst = 1'b0;

        // MAC_LAT=1 build: back-to-back issues never occupy the MAC.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive(1'b1, 2'(i % 3 + 1), 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
            @(negedge clk);
            check($sformatf("lat1 c%0d start", i), 16'(d1_start), 16'd1);
            check($sformatf("lat1 c%0d busy", i),  16'(d1_busy),  16'd0);
            check($sformatf("lat1 c%0d stall", i), 16'({d1_sf, d1_sd, d1_fe}), 16'd0);
            check($sformatf("lat1 c%0d err", i),   16'(d1_err),   16'd0);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("lat1 stall_cnt", d1_cnt, 16'd0);

        // Twenty consecutive load-use stalls: 4-bit counter saturates at 15.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 2'd0, 1'b0, 2'b01, 5'd9, 5'd9, 5'd0, 1'b0);
            @(negedge clk);
            check($sformatf("sat c%0d stall", i), 16'(dp_sd), 16'd1);
            if (i == 16) begin
                check("sat perf4 at 16", 16'(dp_cnt), 16'd15);
            end
        end
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("sat perf4 final", 16'(dp_cnt), 16'd15);
        check("sat perf16 final", d0_cnt, 16'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_mac_ctrl.md
Name: hazard_mac_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core with the multi-cycle MAC unit.
- Tracks MAC occupancy and detects load-use hazards in D.
- Generates stall_f/stall_d (F and D hold), flush_d (F/D clear) and flush_e, which drives the clr input of the decode/execute control and data pipeline registers.
- Issues the MAC start pulse and keeps a saturating stall-cycle performance counter.

Parameters:
- MAC_LAT, 4: total MAC occupancy in cycles, including the issue cycle; legal range 1..16.
- REG_AW, 5: register-index width.
- PERF_W, 16: stall-counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- mac_write_e  in  1  E-stage instruction writes the MAC accumulator
- mac_op_e  in  mac_op_t  E-stage MAC operation (types::mac_op_t)
- mac_use_d  in  1  D-stage instruction is a MAC op or reads the accumulator
- result_src_e  in  2  E-stage result source; 2'b01 = load
- rd_e  in  REG_AW  E-stage destination register
- rs1_d, rs2_d  in  REG_AW  D-stage source registers
- pc_src_e  in  1  taken branch/jump resolved in E
- mac_start  out  1  one-cycle MAC issue pulse
- mac_busy  out  1  MAC occupied (BUSY state)
- stall_f, stall_d  out  1  hold PC and the F/D register
- flush_d, flush_e  out  1  clear F/D; clear D/E (clr)
- mac_err  out  1  sticky protocol-violation flag
- stall_cnt  out  PERF_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, mac_err=0, stall_cnt=0. All combinational outputs are forced to 0 while rst=1.
- issue = mac_write_e && (mac_op_e != MAC_NOP), with MAC_NOP = 2'd0.
- FSM IDLE:
  - issue -> mac_start=1 in the same cycle.
  - If MAC_LAT>1: cnt<=MAC_LAT-2, next state BUSY. Otherwise stay in IDLE.
- FSM BUSY:
  - mac_busy=1.
  - cnt>0 -> cnt<=cnt-1.
  - cnt==0 -> IDLE.
  - BUSY therefore lasts exactly MAC_LAT-1 cycles.
- issue while in BUSY is a protocol violation:
  - No mac_start, state and cnt unchanged.
  - mac_err<=1, held until reset.
- mac_hz = mac_use_d && (state==BUSY || (issue && MAC_LAT>1)).
- lu_hz = (result_src_e==2'b01) && (rd_e!=0) && (rd_e==rs1_d || rd_e==rs2_d).
- Priority, highest first:
  - pc_src_e=1 -> flush_d=1, flush_e=1, stall_f=stall_d=0 (the stalled D instruction is wrong-path).
  - else mac_hz or lu_hz -> stall_f=stall_d=1, flush_e=1 (bubble), flush_d=0.
  - else all four outputs 0.
- A branch flush never aborts an in-flight MAC; BUSY continues counting.
- stall_cnt increments on every cycle with stall_d=1 and saturates at all-ones (no wrap).
- Combinational path: the hazard outputs depend on inputs and state only; there is no register between them and the pipeline enables.
- Reset mid-BUSY returns the FSM to IDLE immediately. The MAC datapath is reset by the same rst.

Decomposition:
- types package:
  - MAC_NOP localparam (mac_op_t'(2'd0)).
  - RES_SRC_LOAD = 2'b01.
  - hz_state_t enum {HZ_IDLE, HZ_BUSY}.
- One natural sub-module: mac_occ_counter (FSM plus down-counter producing mac_start, mac_busy, mac_err).
- Hazard priority logic and the perf counter live in the top module.

Test Plan:
- MAC_LAT=4; issue at cycle 0 with mac_use_d=1 throughout:
  - mac_start=1 at cycle 0 only; mac_busy=1 at cycles 1-3.
  - stall_d=flush_e=1 at cycles 0-3, deasserted at cycle 4; stall_cnt=4.
- Load-use:
  - result_src_e=01, rd_e=5, rs2_d=5 -> one cycle stall_f=stall_d=flush_e=1.
  - rd_e=0 with rs1_d=0 -> no stall.
- pc_src_e=1 during BUSY with mac_use_d=1:
  - flush_d=flush_e=1, stall_f=stall_d=0.
  - mac_busy stays 1 and falls on schedule.
- Second issue during BUSY (mac_use_d forced 0):
  - mac_start stays 0 and mac_err=1 persists.
  - rst pulse mid-BUSY -> mac_busy, mac_err and stall_cnt all 0 asynchronously.
- MAC_LAT=1 build: back-to-back issues with mac_use_d=1 -> mac_start every cycle, no stalls, mac_busy never 1.
- PERF_W=4, 20 consecutive stall cycles -> stall_cnt saturates at 15.
